uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a byte FIFO. Frame format and bit period are
// captured when a byte leaves the FIFO, so configuration may change at any time.
module uart_tx_cfg #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_en,
    input  logic [DIV_W-1:0]         divisor,
    input  logic [1:0]               data_bits,
    input  logic [1:0]               parity,
    input  logic                     stop2,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]       mem_q [DEPTH];
    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DIV_W-1:0] clk_cnt_q, clk_cnt_d, div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d, last_q, last_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic             stop2_q, stop2_d, tx_q, tx_d;

    logic       push, pop, bit_end, stop_last, launch;
    logic [7:0] head, mask;

    assign wr_ready   = (count_q < FULL);
    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        clk_cnt_d = clk_cnt_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        push      = wr_valid && wr_ready;
        head      = mem_q[rd_ptr_q];
        mask      = 8'hFF >> (2'd3 - data_bits);
        bit_end   = (clk_cnt_q == (div_q - DIV_ONE));
        stop_last = stop2_q ? (bit_cnt_q == 3'd1) : 1'b1;
        launch    = tx_en && (count_q != '0) &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_end && stop_last));

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + DIV_ONE;
        end

        case (state_q)
            IDLE: clk_cnt_d = '0;
            START: if (bit_end) begin
                state_d   = DATA;
                tx_d      = shift_q[0];
                bit_cnt_d = 3'd0;
            end
            DATA: if (bit_end) begin
                if (bit_cnt_q == last_q) begin
                    state_d   = par_en_q ? PARITY : STOP;
                    tx_d      = par_en_q ? par_bit_q : 1'b1;
                    bit_cnt_d = 3'd0;
                end else begin
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: if (bit_end) begin
                state_d   = STOP;
                tx_d      = 1'b1;
                bit_cnt_d = 3'd0;
            end
            STOP: if (bit_end) begin
                if (stop_last) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A frame launch overrides the per-state update, including stop-to-start chaining.
        if (launch) begin
            pop       = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            clk_cnt_d = '0;
            bit_cnt_d = 3'd0;
            shift_d   = head;
            div_d     = (divisor < DIV_MIN) ? DIV_MIN : divisor;
            last_d    = {1'b1, data_bits};
            par_en_d  = parity[0] ^ parity[1];
            par_bit_d = (^(head & mask)) ^ parity[1];
            stop2_d   = stop2;
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            clk_cnt_q <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            last_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            clk_cnt_q <= clk_cnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: expected frames are queued as bytes are written and
// a line monitor checks every bit period of each frame as it appears on tx.
module tb_uart_tx_cfg;
    logic        clk = 1'b0;
    logic        reset;
    logic        tx_en;
    logic [15:0] divisor;
    logic [1:0]  data_bits;
    logic [1:0]  parity;
    logic        stop2;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_count;

    typedef struct {
        logic [7:0] d;
        int         div;
        int         nb;
        logic [1:0] par;
        logic       s2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   frames_done = 0;
    int   prev_end_cyc = -1;
    int   gap_sum = 0;
    int   base;
    int   n;

    uart_tx_cfg #(.DEPTH(16), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .divisor(divisor),
        .data_bits(data_bits), .parity(parity), .stop2(stop2),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int ediv, input bit accept);
        exp_t e;
        wr_valid = 1'b1;
        wr_data  = d;
        if (accept) begin
            e.d = d; e.div = ediv; e.nb = data_bits + 5; e.par = parity; e.s2 = stop2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic run_frame();
        exp_t       e;
        logic [11:0] bv;
        int         nbit;
        logic       p;
        logic       aborted;
        logic       badv;
        e = sb.pop_front();
        if (prev_end_cyc >= 0) gap_sum += cyc - prev_end_cyc - 1;
        bv = '1;
        bv[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < e.nb; i++) begin
            bv[1 + i] = e.d[i];
            p = p ^ e.d[i];
        end
        nbit = 1 + e.nb;
        if (e.par == 2'b01 || e.par == 2'b10) begin
            bv[nbit] = (e.par == 2'b10) ? ~p : p;
            nbit++;
        end
        nbit += e.s2 ? 2 : 1;
        aborted = 1'b0;
        for (int b = 0; b < nbit && !aborted; b++) begin
            badv = bv[b];
            for (int c = 0; c < e.div; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (reset !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== bv[b] && badv === bv[b]) badv = tx;
            end
            if (!aborted)
                check($sformatf("frame_%02h_bit%0d", e.d, b), {31'd0, badv}, {31'd0, bv[b]});
        end
        if (!aborted) begin
            frames_done++;
            prev_end_cyc = cyc;
        end
    endtask

    initial begin : line_monitor
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    for (int k = 0; k < 64 && tx === 1'b0; k++) @(negedge clk);
                end else begin
                    run_frame();
                end
            end
        end
    end

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frames_done >= target) break;
        end
        check("frames_completed", frames_done, target);
    endtask

    task automatic run_one(input string name, input logic [7:0] d, input int ediv, input int exp_busy);
        int c;
        base = frames_done;
        push(d, ediv, 1'b1);
        count_busy(c);
        check(name, c, exp_busy);
        check("frame_seen", frames_done, base + 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tx_en = 1'b0; divisor = 16'd4; data_bits = 2'b11; parity = 2'b00;
        stop2 = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_wr_ready", wr_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic formats
        tx_en = 1'b1;
        run_one("busy_8n1_div4", 8'h55, 4, 40);
        divisor = 16'd3; data_bits = 2'b10; parity = 2'b01;
        run_one("busy_7e1_div3", 8'h41, 3, 30);
        divisor = 16'd2; data_bits = 2'b11; parity = 2'b10; stop2 = 1'b1;
        run_one("busy_8o2_div2", 8'hFF, 2, 24);
        divisor = 16'd0; data_bits = 2'b00; parity = 2'b01; stop2 = 1'b0;
        run_one("busy_5e1_div0", 8'h13, 2, 16);
        divisor = 16'd1; data_bits = 2'b01; parity = 2'b10;
        run_one("busy_6o1_div1", 8'h2A, 2, 18);
        divisor = 16'd2; data_bits = 2'b11; parity = 2'b11;
        run_one("busy_par11_none", 8'hC3, 2, 20);

        // Fill FIFO with transmit disabled, overflow write, then drain back-to-back
        tx_en = 1'b0; parity = 2'b00;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 2, 1'b1);
        check("full_wr_ready", wr_ready, 0);
        check("full_count", fifo_count, 16);
        push(8'hEE, 2, 1'b0);
        check("overflow_count", fifo_count, 16);
        gap_sum = 0; prev_end_cyc = -1; base = frames_done;
        tx_en = 1'b1;
        wait_frames(base + 16, 16 * 20 + 100);
        check("b2b_gap_cycles", gap_sum, 0);
        repeat (4) @(negedge clk);
        check("drained_busy", busy, 0);
        check("drained_count", fifo_count, 0);

        // tx_en falling mid-frame: current frame completes, next byte waits
        divisor = 16'd4;
        base = frames_done;
        push(8'h5A, 4, 1'b1);
        push(8'h96, 4, 1'b1);
        repeat (5) @(negedge clk);
        tx_en = 1'b0;
        wait_frames(base + 1, 100);
        repeat (2) @(negedge clk);
        check("txen0_busy", busy, 0);
        check("txen0_count", fifo_count, 1);
        repeat (10) @(negedge clk);
        check("txen0_line_idle", tx, 1);
        tx_en = 1'b1;
        wait_frames(base + 2, 100);

        // Divisor change mid-frame applies only to the following frame
        base = frames_done;
        push(8'h3C, 4, 1'b1);
        push(8'hC3, 8, 1'b1);
        repeat (10) @(negedge clk);
        divisor = 16'd8;
        wait_frames(base + 2, 300);

        // Asynchronous reset in the middle of a frame with bytes still queued
        divisor = 16'd4;
        push(8'hA5, 4, 1'b1);
        push(8'h11, 4, 1'b1);
        push(8'h22, 4, 1'b1);
        push(8'h33, 4, 1'b1);
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_wr_ready", wr_ready, 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        check("quiet_after_reset", n, 0);
        base = frames_done;
        push(8'h69, 4, 1'b1);
        wait_frames(base + 1, 100);
        repeat (2) @(negedge clk);
        check("final_count", fifo_count, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
